// File: rtl/inst_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: widths, opcodes, state encoding.
`timescale 1ns/1ps
package inst_sequencer_pkg;

    localparam int INST_W   = 9;
    localparam int STEP_W   = 2;
    localparam int MAX_STEP = 2;

    // Opcodes live in inst[8:6]
    localparam logic [2:0] OPC_MV  = 3'b000;
    localparam logic [2:0] OPC_MVI = 3'b001;
    localparam logic [2:0] OPC_ADD = 3'b010;
    localparam logic [2:0] OPC_SUB = 3'b011;
    localparam logic [2:0] OPC_OR  = 3'b100;
    localparam logic [2:0] OPC_SLT = 3'b101;
    localparam logic [2:0] OPC_SLL = 3'b110;
    localparam logic [2:0] OPC_SLR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IMM  = 2'd1,
        ST_EXEC = 2'd2
    } state_t;

    // Only mvi needs a second bus word before it can execute
    function automatic logic inst_needs_imm(input logic [INST_W-1:0] w);
        return w[8:6] == OPC_MVI;
    endfunction

endpackage

// File: rtl/inst_sequencer_pend_buf.sv
// One-deep holding register for a run word that arrives while an instruction executes.
// A push while full drops the word and raises o_overflow for that cycle; a pop
// in the same cycle does not make room for it.
`timescale 1ns/1ps
module inst_sequencer_pend_buf
    import inst_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [INST_W-1:0] i_din,
    output logic              o_valid,
    output logic [INST_W-1:0] o_data,
    output logic              o_overflow
);

    logic              r_valid;
    logic [INST_W-1:0] r_data;

    assign o_valid    = r_valid;
    assign o_data     = r_data;
    assign o_overflow = i_push && r_valid;

    // Hold at most one word; a pop empties the slot, a push fills an empty slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_pop) begin
            r_valid <= 1'b0;
        end else if (i_push && !r_valid) begin
            r_valid <= 1'b1;
            r_data  <= i_din;
        end
    end

endmodule

// File: rtl/inst_sequencer.sv
// Instruction sequencer: latches instruction words, steps the control unit until it
// reports done, fetches the mvi immediate, and buffers one early run strobe.
//
// Handshake: i_run is a one-cycle strobe with no back-pressure. A word offered in
// IDLE (or on the edge the current instruction finishes) starts at once; in IMM it
// is the immediate; otherwise it is parked in the pending buffer or, if that is
// full, dropped with o_err_overflow set.
`timescale 1ns/1ps
module inst_sequencer
    import inst_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_run,
    input  logic [INST_W-1:0] i_din,
    input  logic              i_ctrlu_instDone,
    output logic [INST_W-1:0] o_ctrlu_inst,
    output logic [STEP_W-1:0] o_ctrlu_step,
    output logic [INST_W-1:0] o_imm_data,
    output logic              o_imm_req,
    output logic              o_exec_en,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err_timeout,
    output logic              o_err_overflow,
    output state_t            o_state
);

    state_t            r_state;
    logic [INST_W-1:0] r_inst;
    logic [STEP_W-1:0] r_step;
    logic [INST_W-1:0] r_imm_data;
    logic              r_imm_req;
    logic              r_exec_en;
    logic              r_busy;
    logic              r_done;
    logic              r_err_timeout;
    logic              r_err_overflow;

    logic              w_slot;
    logic              w_start;
    logic [INST_W-1:0] w_word;
    logic              w_push;
    logic              w_pop;
    logic              w_pend_valid;
    logic [INST_W-1:0] w_pend_data;
    logic              w_ovf;

    inst_sequencer_pend_buf u_pend_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_din     (i_din),
        .o_valid   (w_pend_valid),
        .o_data    (w_pend_data),
        .o_overflow(w_ovf)
    );

    // Decide where the next instruction comes from; the buffered word is older, so it wins
    always_comb begin
        w_slot  = (r_state == ST_IDLE) || ((r_state == ST_EXEC) && i_ctrlu_instDone);
        w_start = w_slot && (w_pend_valid || i_run);
        w_word  = w_pend_valid ? w_pend_data : i_din;
        w_pop   = w_slot && w_pend_valid;
        w_push  = i_run && (((r_state == ST_EXEC) && !i_ctrlu_instDone) || (w_slot && w_pend_valid));
    end

    // Sequencer FSM with all outputs registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_inst         <= '0;
            r_step         <= '0;
            r_imm_data     <= '0;
            r_imm_req      <= 1'b0;
            r_exec_en      <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_inst         <= w_word;
                        r_step         <= '0;
                        r_busy         <= 1'b1;
                        r_err_timeout  <= 1'b0;
                        r_err_overflow <= 1'b0;
                        if (inst_needs_imm(w_word)) begin
                            r_state   <= ST_IMM;
                            r_imm_req <= 1'b1;
                        end else begin
                            r_state   <= ST_EXEC;
                            r_exec_en <= 1'b1;
                        end
                    end
                end
                ST_IMM: begin
                    if (i_run) begin
                        r_imm_data <= i_din;
                        r_state    <= ST_EXEC;
                        r_step     <= '0;
                        r_imm_req  <= 1'b0;
                        r_exec_en  <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (i_ctrlu_instDone) begin
                        r_step <= '0;
                        r_done <= 1'b1;
                        if (w_start) begin
                            // Chain straight into the next instruction, no IDLE bubble
                            r_inst <= w_word;
                            if (inst_needs_imm(w_word)) begin
                                r_state   <= ST_IMM;
                                r_imm_req <= 1'b1;
                                r_exec_en <= 1'b0;
                            end else begin
                                r_state   <= ST_EXEC;
                            end
                        end else begin
                            r_state   <= ST_IDLE;
                            r_busy    <= 1'b0;
                            r_exec_en <= 1'b0;
                        end
                    end else if (r_step == STEP_W'(MAX_STEP)) begin
                        // Control unit never finished: abort, keep any buffered word
                        r_err_timeout <= 1'b1;
                        r_state       <= ST_IDLE;
                        r_step        <= '0;
                        r_busy        <= 1'b0;
                        r_exec_en     <= 1'b0;
                    end else begin
                        r_step <= r_step + 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_step    <= '0;
                    r_busy    <= 1'b0;
                    r_exec_en <= 1'b0;
                    r_imm_req <= 1'b0;
                end
            endcase
            // A dropped word is flagged even on the cycle the flags are being cleared
            if (w_ovf) begin
                r_err_overflow <= 1'b1;
            end
        end
    end

    assign o_state        = r_state;
    assign o_ctrlu_inst   = r_inst;
    assign o_ctrlu_step   = r_step;
    assign o_imm_data     = r_imm_data;
    assign o_imm_req      = r_imm_req;
    assign o_exec_en      = r_exec_en;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_err_timeout  = r_err_timeout;
    assign o_err_overflow = r_err_overflow;

endmodule

// File: tb/tb_inst_sequencer.sv
// Bench for inst_sequencer: directed scenarios plus a randomized instruction stream
// checked against a transaction-level model with a latency table and a pending queue.
`timescale 1ns/1ps
module tb_inst_sequencer;
    import inst_sequencer_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              run = 1'b0;
    logic [INST_W-1:0] din = '0;
    logic              cu_on = 1'b1;
    logic              instdone;
    logic [INST_W-1:0] ctrlu_inst;
    logic [STEP_W-1:0] ctrlu_step;
    logic [INST_W-1:0] imm_data;
    logic              imm_req, exec_en, busy, done, err_timeout, err_overflow;
    state_t            state;

    int n_vec = 0;
    int n_err = 0;

    inst_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_run           (run),
        .i_din           (din),
        .i_ctrlu_instDone(instdone),
        .o_ctrlu_inst    (ctrlu_inst),
        .o_ctrlu_step    (ctrlu_step),
        .o_imm_data      (imm_data),
        .o_imm_req       (imm_req),
        .o_exec_en       (exec_en),
        .o_busy          (busy),
        .o_done          (done),
        .o_err_timeout   (err_timeout),
        .o_err_overflow  (err_overflow),
        .o_state         (state)
    );

    // Execution length in steps for each opcode class
    function automatic int lat(input logic [2:0] opc);
        return (opc == OPC_MV || opc == OPC_MVI) ? 1 : 3;
    endfunction

    // Control-unit stand-in: reports done on the last step of the current instruction
    assign instdone = cu_on && exec_en && (ctrlu_step == STEP_W'(lat(ctrlu_inst[8:6]) - 1));

    wire [7:0] obs = {busy, exec_en, imm_req, done, err_timeout, err_overflow, ctrlu_step};

    function automatic logic [7:0] ev(input logic b, input logic e, input logic i, input logic dn,
                                      input logic to, input logic ov, input int s);
        return {b, e, i, dn, to, ov, 2'(s)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_run(input logic [INST_W-1:0] w);
        run = 1'b1;
        din = w;
        tick();
        run = 1'b0;
        din = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2;
        n_vec++;
        if (obs !== 8'h00 || ctrlu_inst !== '0 || imm_data !== '0 || state !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_hold obs=%b inst=%h imm=%h state=%0d expected all zero, IDLE", obs, ctrlu_inst, imm_data, state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (obs !== 8'h00 || state !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_release obs=%b state=%0d expected 00000000 IDLE", obs, state);
        end
    endtask

    task automatic test_mv();
        logic [INST_W-1:0] w;
        w = {OPC_MV, 6'($urandom)};
        drive_run(w);
        n_vec++;
        if (obs !== ev(1, 1, 0, 0, 0, 0, 0) || ctrlu_inst !== w) begin
            n_err++;
            $display("FAIL mv_exec obs=%b inst=%h expected %b inst=%h", obs, ctrlu_inst, ev(1, 1, 0, 0, 0, 0, 0), w);
        end
        tick();
        n_vec++;
        if (obs !== ev(0, 0, 0, 1, 0, 0, 0)) begin
            n_err++;
            $display("FAIL mv_done obs=%b expected %b", obs, ev(0, 0, 0, 1, 0, 0, 0));
        end
        tick();
        n_vec++;
        if (obs !== 8'h00 || ctrlu_inst !== w) begin
            n_err++;
            $display("FAIL mv_idle obs=%b inst=%h expected 00000000 inst=%h", obs, ctrlu_inst, w);
        end
    endtask

    task automatic test_alu();
        logic [INST_W-1:0] w;
        for (int k = 0; k < 6; k++) begin
            w = (k == 0) ? 9'b010_011_100 : {3'(k + 2), 6'($urandom)};
            drive_run(w);
            for (int s = 0; s < 3; s++) begin
                if (s != 0) tick();
                n_vec++;
                if (obs !== ev(1, 1, 0, 0, 0, 0, s) || ctrlu_inst !== w) begin
                    n_err++;
                    $display("FAIL alu_step op=%0d s=%0d obs=%b expected %b", w[8:6], s, obs, ev(1, 1, 0, 0, 0, 0, s));
                end
            end
            tick();
            n_vec++;
            if (obs !== ev(0, 0, 0, 1, 0, 0, 0)) begin
                n_err++;
                $display("FAIL alu_done op=%0d obs=%b expected %b", w[8:6], obs, ev(0, 0, 0, 1, 0, 0, 0));
            end
        end
        tick();
    endtask

    task automatic test_mvi();
        logic [INST_W-1:0] w, imm;
        int d;
        for (int k = 0; k < 3; k++) begin
            w   = (k == 0) ? 9'b001_101_000 : {OPC_MVI, 6'($urandom)};
            imm = (k == 0) ? 9'h0AB : 9'($urandom);
            d   = (k == 0) ? 3 : int'($urandom_range(1, 4));
            drive_run(w);
            for (int c = 0; c < d; c++) begin
                n_vec++;
                if (obs !== ev(1, 0, 1, 0, 0, 0, 0)) begin
                    n_err++;
                    $display("FAIL mvi_wait c=%0d obs=%b expected %b", c, obs, ev(1, 0, 1, 0, 0, 0, 0));
                end
                if (c != d - 1) tick();
            end
            drive_run(imm);
            n_vec++;
            if (obs !== ev(1, 1, 0, 0, 0, 0, 0) || imm_data !== imm || ctrlu_inst !== w) begin
                n_err++;
                $display("FAIL mvi_exec obs=%b imm=%h inst=%h expected %b imm=%h inst=%h", obs, imm_data, ctrlu_inst, ev(1, 1, 0, 0, 0, 0, 0), imm, w);
            end
            tick();
            n_vec++;
            if (obs !== ev(0, 0, 0, 1, 0, 0, 0) || imm_data !== imm) begin
                n_err++;
                $display("FAIL mvi_done obs=%b imm=%h expected %b imm=%h", obs, imm_data, ev(0, 0, 0, 1, 0, 0, 0), imm);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [INST_W-1:0] w_add, w_sub, w_or;
        w_add = 9'b010_011_100;
        w_sub = {OPC_SUB, 6'($urandom)};
        w_or  = {OPC_OR, 6'($urandom)};
        drive_run(w_add);
        tick();
        drive_run(w_sub);
        n_vec++;
        if (obs !== ev(1, 1, 0, 0, 0, 0, 2) || ctrlu_inst !== w_add) begin
            n_err++;
            $display("FAIL b2b_add_s2 obs=%b inst=%h expected %b inst=%h", obs, ctrlu_inst, ev(1, 1, 0, 0, 0, 0, 2), w_add);
        end
        drive_run(w_or);
        n_vec++;
        if (obs !== ev(1, 1, 0, 1, 0, 1, 0) || ctrlu_inst !== w_sub) begin
            n_err++;
            $display("FAIL b2b_chain obs=%b inst=%h expected %b inst=%h", obs, ctrlu_inst, ev(1, 1, 0, 1, 0, 1, 0), w_sub);
        end
        tick();
        tick();
        n_vec++;
        if (obs !== ev(1, 1, 0, 0, 0, 1, 2)) begin
            n_err++;
            $display("FAIL b2b_sub_s2 obs=%b expected %b", obs, ev(1, 1, 0, 0, 0, 1, 2));
        end
        tick();
        n_vec++;
        if (obs !== ev(0, 0, 0, 1, 0, 1, 0) || ctrlu_inst !== w_sub) begin
            n_err++;
            $display("FAIL b2b_sub_done obs=%b inst=%h expected %b inst=%h", obs, ctrlu_inst, ev(0, 0, 0, 1, 0, 1, 0), w_sub);
        end
        tick();
        n_vec++;
        if (obs !== ev(0, 0, 0, 0, 0, 1, 0) || ctrlu_inst !== w_sub) begin
            n_err++;
            $display("FAIL b2b_lost_word obs=%b inst=%h expected %b inst=%h", obs, ctrlu_inst, ev(0, 0, 0, 0, 0, 1, 0), w_sub);
        end
    endtask

    task automatic test_timeout();
        logic [INST_W-1:0] w_mv;
        cu_on = 1'b0;
        drive_run({OPC_ADD, 6'($urandom)});
        n_vec++;
        if (obs !== ev(1, 1, 0, 0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL to_clear_ovf obs=%b expected %b", obs, ev(1, 1, 0, 0, 0, 0, 0));
        end
        tick();
        tick();
        n_vec++;
        if (obs !== ev(1, 1, 0, 0, 0, 0, 2)) begin
            n_err++;
            $display("FAIL to_s2 obs=%b expected %b", obs, ev(1, 1, 0, 0, 0, 0, 2));
        end
        tick();
        n_vec++;
        if (obs !== ev(0, 0, 0, 0, 1, 0, 0) || state !== ST_IDLE) begin
            n_err++;
            $display("FAIL to_abort obs=%b state=%0d expected %b IDLE", obs, state, ev(0, 0, 0, 0, 1, 0, 0));
        end
        tick();
        n_vec++;
        if (obs !== ev(0, 0, 0, 0, 1, 0, 0)) begin
            n_err++;
            $display("FAIL to_sticky obs=%b expected %b", obs, ev(0, 0, 0, 0, 1, 0, 0));
        end
        cu_on = 1'b1;
        drive_run({OPC_MV, 6'($urandom)});
        n_vec++;
        if (obs !== ev(1, 1, 0, 0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL to_cleared obs=%b expected %b", obs, ev(1, 1, 0, 0, 0, 0, 0));
        end
        tick();
        tick();
        // Timeout with a word parked in the buffer: it must survive the abort
        cu_on = 1'b0;
        w_mv = {OPC_MV, 6'($urandom)};
        drive_run({OPC_SLT, 6'($urandom)});
        drive_run(w_mv);
        tick();
        tick();
        n_vec++;
        if (obs !== ev(0, 0, 0, 0, 1, 0, 0)) begin
            n_err++;
            $display("FAIL to_pend_abort obs=%b expected %b", obs, ev(0, 0, 0, 0, 1, 0, 0));
        end
        cu_on = 1'b1;
        tick();
        n_vec++;
        if (obs !== ev(1, 1, 0, 0, 0, 0, 0) || ctrlu_inst !== w_mv) begin
            n_err++;
            $display("FAIL to_pend_start obs=%b inst=%h expected %b inst=%h", obs, ctrlu_inst, ev(1, 1, 0, 0, 0, 0, 0), w_mv);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_midop();
        drive_run({OPC_ADD, 6'($urandom)});
        drive_run({OPC_SUB, 6'($urandom)});
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (obs !== 8'h00 || ctrlu_inst !== '0 || imm_data !== '0 || state !== ST_IDLE) begin
            n_err++;
            $display("FAIL rst_mid obs=%b inst=%h imm=%h state=%0d expected all zero", obs, ctrlu_inst, imm_data, state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        n_vec++;
        if (obs !== 8'h00 || state !== ST_IDLE) begin
            n_err++;
            $display("FAIL rst_buf_empty obs=%b state=%0d expected 00000000 IDLE", obs, state);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 waiting for immediate, 2 executing; age = cycles spent executing
    int                m_phase = 0;
    int                m_age = 0;
    logic [INST_W-1:0] m_inst = '0;
    logic [INST_W-1:0] m_imm = '0;
    logic              m_done = 1'b0, m_eto = 1'b0, m_eov = 1'b0;
    logic [INST_W-1:0] m_pend[$];

    task automatic model_begin(input logic [INST_W-1:0] w);
        m_inst  = w;
        m_age   = 0;
        m_phase = (w[8:6] == OPC_MVI) ? 1 : 2;
    endtask

    task automatic model_edge(input logic r, input logic [INST_W-1:0] d);
        logic finishing;
        finishing = (m_phase == 2) && (m_age + 1 == lat(m_inst[8:6]));
        m_done = 1'b0;
        if (m_phase == 0 || finishing) begin
            if (finishing) begin
                m_done  = 1'b1;
                m_phase = 0;
                m_age   = 0;
            end
            if (m_pend.size() != 0) begin
                if (!finishing) begin m_eto = 1'b0; m_eov = 1'b0; end
                model_begin(m_pend.pop_front());
                if (r) m_eov = 1'b1;
            end else if (r) begin
                if (!finishing) begin m_eto = 1'b0; m_eov = 1'b0; end
                model_begin(d);
            end
        end else if (m_phase == 1) begin
            if (r) begin
                m_imm   = d;
                m_phase = 2;
                m_age   = 0;
            end
        end else begin
            if (r) begin
                if (m_pend.size() == 0) m_pend.push_back(d);
                else m_eov = 1'b1;
            end
            m_age++;
        end
    endtask

    task automatic test_random_stream();
        logic              r;
        logic [INST_W-1:0] d;
        logic [7:0]        e;
        for (int i = 0; i < 400; i++) begin
            r = (i < 390) && ($urandom_range(0, 2) == 0);
            d = 9'($urandom);
            run = r;
            din = d;
            model_edge(r, d);
            tick();
            run = 1'b0;
            e = ev(m_phase != 0, m_phase == 2, m_phase == 1, m_done, m_eto, m_eov, m_age);
            n_vec++;
            if (obs !== e || ctrlu_inst !== m_inst || imm_data !== m_imm) begin
                n_err++;
                $display("FAIL stream cyc=%0d obs=%b inst=%h imm=%h expected %b inst=%h imm=%h", i, obs, ctrlu_inst, imm_data, e, m_inst, m_imm);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_mv();
        test_alu();
        test_mvi();
        test_back_to_back();
        test_timeout();
        test_reset_midop();
        test_random_stream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog bench did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
